// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-style pipeline stages.
// - DATA_W_DEF / REG_W_DEF : default datapath and register-index widths
// - CTRL_* : bit positions inside the MEM/WB control vector
// - skid_state_e : occupancy of a two-entry skid stage
package mips_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_skid_stage_sat_counter.sv
// Saturating up-counter.
// - clk : rising-edge clock
// - clr : synchronous clear (wins over inc)
// - inc : advance by one unless already at the all-ones ceiling
// - cnt : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (clr)      cnt_p1 <= '0;
    else if (inc) cnt_p1 <= sat_inc(cnt_p1);
  end

  assign cnt = cnt_p1;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry catches the one bundle
// that can arrive while in_ready (registered) is still high after MEM stalls.
// - clk, rst (sync, active-high), flush (sync, drops everything in flight)
// - in_valid/in_ready + in_alu/in_wdata/in_btgt/in_rd/in_ctrl : from EX
// - out_valid/out_ready + out_alu/out_wdata/out_btgt/out_rd/out_ctrl : to MEM
//   (out_ctrl reads 0 whenever out_valid is low)
// - stall_cnt : saturating count of cycles MEM held off a valid bundle
module ex_mem_skid_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int REG_W         = REG_W_DEF,
  parameter int CTRL_W        = 4,
  parameter int CNT_W         = 16,
  parameter bit RESET_PAYLOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_btgt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_btgt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PAY_W = 3*DATA_W + REG_W + CTRL_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_p1;
  logic [PAY_W-1:0] skid_p1;
  skid_state_e      state_p1;
  skid_state_e      state_nxt;
  logic             in_ready_p1;

  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;
  logic drop_all;

  logic [CTRL_W-1:0] main_ctrl;

  assign in_pay   = {in_btgt, in_wdata, in_alu, in_rd, in_ctrl};
  assign in_fire  = in_valid & in_ready_p1;
  assign out_fire = out_valid & out_ready;
  assign drop_all = rst | flush;

  always_comb begin
    state_nxt    = state_p1;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_p1)
      EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nxt  = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          ld_skid   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Reset/flush override every handshake and suppress payload loads so the
    // registers hold when RESET_PAYLOAD is 0.
    if (drop_all) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Stage boundary: occupancy and registered ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1    <= EMPTY;
      in_ready_p1 <= 1'b1;
    end else begin
      state_p1    <= state_nxt;
      in_ready_p1 <= (state_nxt != FULL);
    end
  end

  // Stage boundary: main/skid payload
  always_ff @(posedge clk) begin
    if (RESET_PAYLOAD && drop_all) begin
      main_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (ld_main_in)        main_p1 <= in_pay;
      else if (ld_main_skid) main_p1 <= skid_p1;
      if (ld_skid)           skid_p1 <= in_pay;
    end
  end

  assign in_ready  = in_ready_p1;
  assign out_valid = (state_p1 != EMPTY);

  assign {out_btgt, out_wdata, out_alu, out_rd, main_ctrl} = main_p1;
  assign out_ctrl = out_valid ? main_ctrl : '0;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (out_valid & ~out_ready & ~flush),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
module tb_ex_mem_skid_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_alu, in_wdata, in_btgt;
  logic [RW-1:0] in_rd;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] out_alu, out_wdata, out_btgt;
  logic [RW-1:0] out_rd;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  ex_mem_skid_stage #(
    .DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .CNT_W(NW), .RESET_PAYLOAD(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_wdata(in_wdata), .in_btgt(in_btgt),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu(out_alu), .out_wdata(out_wdata), .out_btgt(out_btgt),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  // Reference model: a bounded FIFO of bundles plus a saturating integer.
  typedef struct {
    logic [DW-1:0] alu, wdata, btgt;
    logic [RW-1:0] rd;
    logic [CW-1:0] ctrl;
  } bun_t;

  bun_t q[$];
  int   m_cnt = 0;
  int   n_checks = 0;
  int   n_err = 0;

  typedef struct {
    logic r, f, iv, ordy;
    logic [DW-1:0] alu;
    logic ev, er;
    logic [DW-1:0] ealu;
    logic [NW-1:0] estall;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bun_t mk(input logic [DW-1:0] a);
    bun_t b;
    b.alu   = a;
    b.wdata = a ^ 32'hA5A5_0000;
    b.btgt  = a + 32'h1000;
    b.rd    = a[4:0] ^ 5'h13;
    b.ctrl  = a[3:0] ^ 4'hA;
    return b;
  endfunction

  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input logic [DW-1:0] a);
    bun_t b;
    bit   m_ir, m_ov;
    b = mk(a);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_alu = b.alu; in_wdata = b.wdata; in_btgt = b.btgt; in_rd = b.rd; in_ctrl = b.ctrl;
    m_ir = (q.size() < 2);
    m_ov = (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (m_ov && !ordy && !f && m_cnt < (1 << NW) - 1) m_cnt++;
      if (f) q.delete();
      else begin
        if (m_ov && ordy) void'(q.pop_front());
        if (iv && m_ir) q.push_back(b);
      end
    end
    #1;
    chk("model out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("model in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
    chk("model stall_cnt", {28'd0, stall_cnt}, m_cnt[DW-1:0]);
    if (q.size() > 0) begin
      chk("model out_alu",   out_alu,   q[0].alu);
      chk("model out_wdata", out_wdata, q[0].wdata);
      chk("model out_btgt",  out_btgt,  q[0].btgt);
      chk("model out_rd",    {27'd0, out_rd},   {27'd0, q[0].rd});
      chk("model out_ctrl",  {28'd0, out_ctrl}, {28'd0, q[0].ctrl});
    end else begin
      chk("model bubble ctrl", {28'd0, out_ctrl}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu = '0; in_wdata = '0; in_btgt = '0; in_rd = '0; in_ctrl = '0;

    // Directed vectors: {rst,flush,in_valid,out_ready,alu, exp valid,ready,alu,stall}
    tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  4'd0});
    tv.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  4'd0});
    for (int k = 0; k < 8; k++)
      tv.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 32'(k), 1'b1, 1'b1, 32'(k), 4'd0});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0,  4'd0});
    tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 32'h11, 4'd0});
    tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h22, 1'b1, 1'b0, 32'h11, 4'd1});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h11, 4'd2});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h11, 4'd3});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h22, 4'd3});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0,  4'd3});
    tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 32'h33, 4'd3});
    tv.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 32'h33, 4'd4});
    tv.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h55, 1'b0, 1'b1, 32'h0,  4'd4});
    tv.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0,  4'd4});

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].r, tv[i].f, tv[i].iv, tv[i].ordy, tv[i].alu);
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].ev});
      chk($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, tv[i].er});
      chk($sformatf("vec%0d stall_cnt", i), {28'd0, stall_cnt}, {28'd0, tv[i].estall});
      if (tv[i].ev) chk($sformatf("vec%0d out_alu", i), out_alu, tv[i].ealu);
      else          chk($sformatf("vec%0d out_ctrl", i), {28'd0, out_ctrl}, 32'd0);
    end

    // Saturation: one bundle held for 20 stalled cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h77);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sat stall_cnt", {28'd0, stall_cnt}, 32'd15);
    chk("sat out_alu held", out_alu, 32'h77);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("sat stall_cnt after release", {28'd0, stall_cnt}, 32'd15);

    // Simultaneous fire on both sides keeps a single entry and order.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100 + 32'(i));
      chk($sformatf("simul%0d out_alu", i), out_alu, 32'h100 + 32'(i));
      chk($sformatf("simul%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("simul drained", {31'd0, out_valid}, 32'd0);

    // Randomized traffic against the model.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
